// File: rtl/pia_pkg.sv
// pia_pkg: shared definitions for the pia_fifo_port peripheral.
//   - register offsets within the 4-byte window
//   - status bit positions used by the CTL registers
//   - keyboard handshake FSM state encoding
//   - value returned when the keyboard data register is read while empty
//   - address window decode helpers
package pia_pkg;

    localparam logic [1:0] PIA_OFS_KBD_DATA = 2'd0;
    localparam logic [1:0] PIA_OFS_KBD_CTL  = 2'd1;
    localparam logic [1:0] PIA_OFS_DSP_DATA = 2'd2;
    localparam logic [1:0] PIA_OFS_DSP_CTL  = 2'd3;

    localparam int CTL_NEMPTY = 7;
    localparam int CTL_FULL   = 6;
    localparam int CTL_IRQEN  = 0;

    localparam logic [7:0] PIA_EMPTY_READ = 8'h80;

    typedef enum logic [1:0] {
        K_IDLE = 2'd0,
        K_ACK  = 2'd1,
        K_WAIT = 2'd2
    } kbd_state_e;

    // True when addr falls in base..base+3. Uses the wrapped difference so the
    // base need not be 4-byte aligned.
    function automatic logic pia_in_window(input logic [15:0] addr,
                                           input logic [15:0] base);
        logic [15:0] diff;
        diff = addr - base;
        return (diff[15:2] == 14'd0);
    endfunction

    function automatic logic [1:0] pia_offset(input logic [15:0] addr,
                                              input logic [15:0] base);
        logic [15:0] diff;
        diff = addr - base;
        return diff[1:0];
    endfunction

endpackage

// File: rtl/pia_sync_fifo.sv
// pia_sync_fifo: single-clock FIFO used for both the RX and TX queues.
// Ports:
//   clk, reset       clock, synchronous active-high reset (empties the FIFO)
//   push_i, data_i   write request and data; refused while full, even if a
//                    pop happens in the same cycle
//   pop_i            read request; ignored while empty
//   full_o, empty_o  status flags
//   count_o          occupancy, $clog2(DEPTH)+1 bits
//   head_o           oldest entry, forced to 0 while empty
module pia_sync_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 7
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic [DATA_W-1:0]          data_i,
    input  logic                       pop_i,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [DATA_W-1:0]          head_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q, count_d;
    logic              push_ok, pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign count_o = count_q;
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + CW'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CW'(1);
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_d;
        end
    end

    // Storage needs no reset: head_o is masked while empty.
    always_ff @(posedge clk) begin
        if (push_ok && !reset) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/pia_fifo_port.sv
// pia_fifo_port: memory-mapped keyboard RX / display TX FIFO peripheral.
// Register window BASE_ADDR+0..+3: KBD_DATA, KBD_CTL, DSP_DATA, DSP_CTL.
// Ports:
//   clk, reset               CPU clock, synchronous active-high reset
//   AB, DI, WE               CPU address, write data, write enable
//   dout, hit                read data / read hit, from the latched address
//   kbd_rdy, kbd_ack, kbd_data   keyboard source handshake
//   dsp_rdy, dsp_ack, dsp_data   display sink handshake
//   irq                      interrupt request (RX not empty and enabled)
// Build option: define PIA_FIFO_IRQ_EN to enable the interrupt and the
// KBD_CTL irq_en bit; otherwise irq is 0 and irq_en reads 0.
//
// Keyboard FSM
//   state  | meaning
//   K_IDLE | waiting for kbd_rdy with room in RX; push on entry to K_ACK
//   K_ACK  | kbd_ack high for this single cycle
//   K_WAIT | waiting for kbd_rdy to drop so a held character is not re-pushed
module pia_fifo_port
    import pia_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'hD010,
    parameter int          DEPTH     = 4,
    parameter int          DATA_W    = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       AB,
    input  logic [7:0]        DI,
    input  logic              WE,
    output logic [7:0]        dout,
    output logic              hit,
    input  logic              kbd_rdy,
    output logic              kbd_ack,
    input  logic [DATA_W-1:0] kbd_data,
    output logic              dsp_rdy,
    input  logic              dsp_ack,
    output logic [DATA_W-1:0] dsp_data,
    output logic              irq
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [15:0]       ab_q;
    logic              rd_vld_q;
    logic [1:0]        rd_ofs, wr_ofs;
    logic              wr_en;
    logic              irq_en;

    kbd_state_e        kbd_state_q, kbd_state_d;

    logic              rx_push, rx_pop, rx_full, rx_empty;
    logic [CW-1:0]     rx_count;
    logic [DATA_W-1:0] rx_head;
    logic              tx_push, tx_full, tx_empty;
    logic [CW-1:0]     tx_count;
    logic [DATA_W-1:0] tx_head;
    logic [6:0]        rx_char;

    // rd_vld_q keeps hit low straight out of reset even if BASE_ADDR is 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            ab_q     <= '0;
            rd_vld_q <= 1'b0;
        end else begin
            ab_q     <= AB;
            rd_vld_q <= 1'b1;
        end
    end

    assign hit    = rd_vld_q && !WE && pia_in_window(ab_q, BASE_ADDR);
    assign rd_ofs = pia_offset(ab_q, BASE_ADDR);
    assign wr_en  = WE && pia_in_window(AB, BASE_ADDR);
    assign wr_ofs = pia_offset(AB, BASE_ADDR);

    assign rx_pop  = hit && (rd_ofs == PIA_OFS_KBD_DATA) && !rx_empty;
    assign tx_push = wr_en && (wr_ofs == PIA_OFS_DSP_DATA);

    pia_sync_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_rx_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (rx_push),
        .data_i  (kbd_data),
        .pop_i   (rx_pop),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .count_o (rx_count),
        .head_o  (rx_head)
    );

    pia_sync_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_tx_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (tx_push),
        .data_i  (DI[DATA_W-1:0]),
        .pop_i   (dsp_ack),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .count_o (tx_count),
        .head_o  (tx_head)
    );

    assign dsp_rdy  = !tx_empty;
    assign dsp_data = tx_head;

    always_ff @(posedge clk) begin
        if (reset) begin
            kbd_state_q <= K_IDLE;
        end else begin
            kbd_state_q <= kbd_state_d;
        end
    end

    always_comb begin
        kbd_state_d = kbd_state_q;
        rx_push     = 1'b0;
        case (kbd_state_q)
            K_IDLE: begin
                if (kbd_rdy && !rx_full) begin
                    rx_push     = 1'b1;
                    kbd_state_d = K_ACK;
                end
            end
            K_ACK: begin
                kbd_state_d = K_WAIT;
            end
            K_WAIT: begin
                if (!kbd_rdy) begin
                    kbd_state_d = K_IDLE;
                end
            end
            default: begin
                kbd_state_d = K_IDLE;
            end
        endcase
    end

    assign kbd_ack = (kbd_state_q == K_ACK);

`ifdef PIA_FIFO_IRQ_EN
    logic irq_en_q, irq_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (wr_en && (wr_ofs == PIA_OFS_KBD_CTL)) begin
                irq_en_q <= DI[CTL_IRQEN];
            end
            irq_q <= irq_en_q && !rx_empty;
        end
    end

    assign irq_en = irq_en_q;
    assign irq    = irq_q;
`else
    assign irq_en = 1'b0;
    assign irq    = 1'b0;
`endif

    always_comb begin
        rx_char                 = '0;
        rx_char[DATA_W-1:0]     = rx_head;
        dout                    = '0;
        if (hit) begin
            case (rd_ofs)
                PIA_OFS_KBD_DATA: begin
                    dout = rx_empty ? PIA_EMPTY_READ : {1'b1, rx_char};
                end
                PIA_OFS_KBD_CTL: begin
                    dout[CTL_NEMPTY] = !rx_empty;
                    dout[CTL_FULL]   = rx_full;
                    dout[CTL_IRQEN]  = irq_en;
                end
                PIA_OFS_DSP_DATA: begin
                    dout[CTL_NEMPTY] = tx_full;
                end
                default: begin
                    dout[CTL_NEMPTY] = tx_empty;
                    dout[CTL_FULL]   = tx_full;
                end
            endcase
        end
    end

    // Occupancy counts and the DI bits above the character width have no
    // consumer here.
    logic unused_bits;
    assign unused_bits = ^{DI, rx_count, tx_count};

endmodule

// File: tb/tb_pia_fifo_port.sv
module tb_pia_fifo_port;

    localparam logic [15:0] BASE = 16'hD010;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] AB;
    logic [7:0]  DI;
    logic        WE;
    logic [7:0]  dout;
    logic        hit;
    logic        kbd_rdy;
    logic        kbd_ack;
    logic [6:0]  kbd_data;
    logic        dsp_rdy;
    logic        dsp_ack;
    logic [6:0]  dsp_data;
    logic        irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pia_fifo_port #(.BASE_ADDR(BASE), .DEPTH(4), .DATA_W(7)) dut (
        .clk      (clk),
        .reset    (reset),
        .AB       (AB),
        .DI       (DI),
        .WE       (WE),
        .dout     (dout),
        .hit      (hit),
        .kbd_rdy  (kbd_rdy),
        .kbd_ack  (kbd_ack),
        .kbd_data (kbd_data),
        .dsp_rdy  (dsp_rdy),
        .dsp_ack  (dsp_ack),
        .dsp_data (dsp_data),
        .irq      (irq)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [1:0] ofs, output logic [7:0] d);
        AB = BASE + 16'(ofs);
        WE = 1'b0;
        step();
        AB = 16'h0000;
        #1;
        chk("rd_hit", 32'(hit), 32'd1);
        d = dout;
        step();
    endtask

    task automatic rd_chk(input logic [1:0] ofs, input logic [7:0] exp, input string tag);
        logic [7:0] d;
        rd(ofs, d);
        chk(tag, 32'(d), 32'(exp));
    endtask

    task automatic wr(input logic [1:0] ofs, input logic [7:0] data);
        AB = BASE + 16'(ofs);
        DI = data;
        WE = 1'b1;
        step();
        WE = 1'b0;
        AB = 16'h0000;
        DI = 8'h00;
    endtask

    task automatic key(input logic [6:0] ch);
        kbd_data = ch;
        kbd_rdy  = 1'b1;
        step();
        kbd_rdy  = 1'b0;
        step();
        step();
    endtask

    task automatic pop_chk(input logic [6:0] exp, input string tag);
        #1;
        chk(tag, 32'(dsp_data), 32'(exp));
        dsp_ack = 1'b1;
        step();
        dsp_ack = 1'b0;
    endtask

    task automatic sim_push_pop(input logic [7:0] data, input logic [6:0] exp_head, input string tag);
        #1;
        chk(tag, 32'(dsp_data), 32'(exp_head));
        AB      = BASE + 16'd2;
        DI      = data;
        WE      = 1'b1;
        dsp_ack = 1'b1;
        step();
        WE      = 1'b0;
        dsp_ack = 1'b0;
        AB      = 16'h0000;
        DI      = 8'h00;
    endtask

    initial begin
        int acks;
        int ack_at;

        reset    = 1'b1;
        AB       = 16'h0000;
        DI       = 8'h00;
        WE       = 1'b0;
        kbd_rdy  = 1'b0;
        kbd_data = 7'h00;
        dsp_ack  = 1'b0;
        step();
        step();
        #1;
        chk("rst_dout",     32'(dout),     32'h0);
        chk("rst_hit",      32'(hit),      32'h0);
        chk("rst_kbd_ack",  32'(kbd_ack),  32'h0);
        chk("rst_dsp_rdy",  32'(dsp_rdy),  32'h0);
        chk("rst_dsp_data", 32'(dsp_data), 32'h0);
        chk("rst_irq",      32'(irq),      32'h0);
        reset = 1'b0;
        step();

        rd_chk(2'd1, 8'h00, "kbd_ctl_rst");
        rd_chk(2'd3, 8'h80, "dsp_ctl_rst");
        chk("dsp_rdy_idle", 32'(dsp_rdy), 32'h0);
        chk("irq_idle",     32'(irq),     32'h0);

        // Held kbd_rdy: exactly one ack, one cycle after the push.
        kbd_data = 7'h41;
        kbd_rdy  = 1'b1;
        acks     = 0;
        ack_at   = -1;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (kbd_ack) begin
                acks++;
                ack_at = i;
            end
            step();
        end
        chk("held_ack_count", 32'(acks), 32'd1);
        chk("held_ack_cycle", 32'(ack_at), 32'd1);
        kbd_rdy = 1'b0;
        step();
        rd_chk(2'd1, 8'h80, "kbd_ctl_one");
        rd_chk(2'd0, 8'hC1, "kbd_data_41");
        rd_chk(2'd0, 8'h80, "kbd_data_empty");

        // TX overflow: fifth write dropped.
        for (int i = 0; i < 5; i++) begin
            wr(2'd2, 8'(8'h30 + i));
        end
        #1;
        chk("tx_rdy_after_wr", 32'(dsp_rdy), 32'd1);
        rd_chk(2'd2, 8'h80, "dsp_busy_full");
        rd_chk(2'd3, 8'h40, "dsp_ctl_full");
        for (int i = 0; i < 4; i++) begin
            pop_chk(7'(7'h30 + i), "tx_order");
        end
        #1;
        chk("tx_drained_rdy",  32'(dsp_rdy),  32'd0);
        chk("tx_drained_data", 32'(dsp_data), 32'd0);

        // Ack while empty is ignored; next write is the new head.
        dsp_ack = 1'b1;
        step();
        dsp_ack = 1'b0;
        wr(2'd2, 8'h3A);
        pop_chk(7'h3A, "tx_after_empty_ack");

        // Simultaneous push/pop across pointer wrap.
        wr(2'd2, 8'h60);
        wr(2'd2, 8'h61);
        wr(2'd2, 8'h62);
        pop_chk(7'h60, "wrap_pop0");
        pop_chk(7'h61, "wrap_pop1");
        wr(2'd2, 8'h63);
        sim_push_pop(8'h64, 7'h62, "sim_head0");
        rd_chk(2'd3, 8'h00, "sim_ctl_two");
        sim_push_pop(8'h65, 7'h63, "sim_head1");
        wr(2'd2, 8'h66);
        wr(2'd2, 8'h67);
        rd_chk(2'd2, 8'h80, "sim_full");
        // Full: the push is refused even though a pop happens.
        sim_push_pop(8'h68, 7'h64, "full_sim_head");
        pop_chk(7'h65, "full_sim_pop0");
        pop_chk(7'h66, "full_sim_pop1");
        pop_chk(7'h67, "full_sim_pop2");
        #1;
        chk("full_sim_empty", 32'(dsp_rdy), 32'd0);

        // RX full blocks the handshake until a CPU pop frees a slot.
        key(7'h50);
        key(7'h51);
        key(7'h52);
        key(7'h53);
        rd_chk(2'd1, 8'hC0, "rx_ctl_full");
        kbd_data = 7'h54;
        kbd_rdy  = 1'b1;
        acks     = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (kbd_ack) acks++;
            step();
        end
        chk("rx_full_no_ack", 32'(acks), 32'd0);
        rd_chk(2'd0, 8'hD0, "rx_full_pop");
        acks   = 0;
        ack_at = -1;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (kbd_ack) begin
                acks++;
                ack_at = i;
            end
            step();
        end
        chk("rx_unblock_acks", 32'(acks), 32'd1);
        chk("rx_unblock_cycle", 32'(ack_at), 32'd1);
        kbd_rdy = 1'b0;
        step();
        step();
        rd_chk(2'd0, 8'hD1, "rx_seq1");
        rd_chk(2'd0, 8'hD2, "rx_seq2");
        rd_chk(2'd0, 8'hD3, "rx_seq3");
        rd_chk(2'd0, 8'hD4, "rx_seq4");
        rd_chk(2'd0, 8'h80, "rx_seq_empty");

        // Interrupt.
        wr(2'd1, 8'h01);
        key(7'h42);
`ifdef PIA_FIFO_IRQ_EN
        #1;
        chk("irq_set", 32'(irq), 32'd1);
        rd_chk(2'd1, 8'h81, "kbd_ctl_irqen");
        rd_chk(2'd0, 8'hC2, "irq_pop_data");
        chk("irq_hold", 32'(irq), 32'd1);
        step();
        chk("irq_clear", 32'(irq), 32'd0);
`else
        #1;
        chk("irq_tied", 32'(irq), 32'd0);
        rd_chk(2'd1, 8'h80, "kbd_ctl_noirqen");
        rd_chk(2'd0, 8'hC2, "irq_pop_data");
        chk("irq_tied_after", 32'(irq), 32'd0);
`endif

        // Reset mid-operation cancels a pending ack and empties both FIFOs.
        wr(2'd2, 8'h71);
        kbd_data = 7'h43;
        kbd_rdy  = 1'b1;
        step();
        chk("ack_before_reset", 32'(kbd_ack), 32'd1);
        reset   = 1'b1;
        kbd_rdy = 1'b0;
        step();
        chk("mid_rst_ack",      32'(kbd_ack),  32'd0);
        chk("mid_rst_dsp_rdy",  32'(dsp_rdy),  32'd0);
        chk("mid_rst_dsp_data", 32'(dsp_data), 32'd0);
        chk("mid_rst_irq",      32'(irq),      32'd0);
        chk("mid_rst_hit",      32'(hit),      32'd0);
        reset = 1'b0;
        step();
        rd_chk(2'd0, 8'h80, "post_rst_rx_empty");
        rd_chk(2'd3, 8'h80, "post_rst_tx_empty");
        rd_chk(2'd1, 8'h00, "post_rst_kbd_ctl");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
